// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, instruction field positions and helpers
// used by the decode and execute stages.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;

  // Bit positions of the RV32I instruction fields
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNC3_LSB  = 12;
  localparam int FUNC3_MSB  = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNC7_LSB  = 25;
  localparam int FUNC7_MSB  = 31;
  localparam int IMM_I_LSB  = 20;
  localparam int IMM_I_MSB  = 31;

  typedef struct packed {
    logic [6:0]            func7;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rs1;
    logic [2:0]            func3;
    logic [REG_ADDR_W-1:0] rd;
    logic [6:0]            opcode;
  } instr_fields_t;

  function automatic instr_fields_t split_fields(input logic [XLEN-1:0] instr);
    instr_fields_t f;
    f.func7  = instr[FUNC7_MSB:FUNC7_LSB];
    f.rs2    = instr[RS2_MSB:RS2_LSB];
    f.rs1    = instr[RS1_MSB:RS1_LSB];
    f.func3  = instr[FUNC3_MSB:FUNC3_LSB];
    f.rd     = instr[RD_MSB:RD_LSB];
    f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    return f;
  endfunction

  function automatic logic [XLEN-1:0] sext_imm_i(input logic [XLEN-1:0] instr);
    return {{20{instr[IMM_I_MSB]}}, instr[IMM_I_MSB:IMM_I_LSB]};
  endfunction

  function automatic logic op_supported(input logic [6:0] opcode);
    return (opcode == OP_ALU) || (opcode == OP_ALUI);
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] opcode);
    return opcode == OP_ALU;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry integer register file: two combinational read ports with
// write-through bypass, one write port, optional clear on reset.
module reg_file
  import riscv_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [DATA_W-1:0]     rs1_data,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]     rs2_data,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data
);

  // Entry 0 is never written; reads of x0 are forced to zero below.
  logic [DATA_W-1:0]     regs_reg [NUM_REGS];
  logic [REG_ADDR_W-1:0] rd_addr  [2];
  logic [DATA_W-1:0]     rd_data  [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        for (int i = 1; i < NUM_REGS; i++) begin
          regs_reg[i] <= '0;
        end
      end
    end else if (wr_addr != '0) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      // A same-cycle writeback wins over the stored value.
      assign rd_data[gi] = (rd_addr[gi] == '0)      ? '0      :
                           (rd_addr[gi] == wr_addr) ? wr_data :
                                                      regs_reg[rd_addr[gi]];
    end
  endgenerate

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

endmodule

// File: rtl/id_stage.sv
// Decode stage: reads operands, registers decoded fields for execute, and
// stalls one cycle when a source matches the instruction now in execute.
module id_stage
  import riscv_pkg::*;
#(
  parameter int DATA_W            = 32,
  parameter bit CLEAR_RF_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        wb_rd_number,
  input  logic [DATA_W-1:0] wb_result,
  output logic [31:0]       pc,
  output logic [DATA_W-1:0] rs1_val,
  output logic [DATA_W-1:0] rs2_val,
  output logic [4:0]        rd_number,
  output logic [31:0]       immediate,
  output logic [6:0]        func7,
  output logic [2:0]        func3,
  output logic [6:0]        opcode,
  output logic              illegal_instr
);

  instr_fields_t     fields;
  logic              supported;
  logic              uses_rs2;
  logic              hazard;
  logic              issue;
  logic [DATA_W-1:0] rf_rs1_data;
  logic [DATA_W-1:0] rf_rs2_data;

  logic [31:0]       pc_reg,        pc_next;
  logic [DATA_W-1:0] rs1_val_reg,   rs1_val_next;
  logic [DATA_W-1:0] rs2_val_reg,   rs2_val_next;
  logic [4:0]        rd_number_reg, rd_number_next;
  logic [31:0]       immediate_reg, immediate_next;
  logic [6:0]        func7_reg,     func7_next;
  logic [2:0]        func3_reg,     func3_next;
  logic [6:0]        opcode_reg,    opcode_next;
  logic              illegal_reg,   illegal_next;

  assign fields = split_fields(instr);

  reg_file #(
    .DATA_W        (DATA_W),
    .CLEAR_ON_RESET(CLEAR_RF_ON_RESET)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .rs1_addr(fields.rs1),
    .rs1_data(rf_rs1_data),
    .rs2_addr(fields.rs2),
    .rs2_data(rf_rs2_data),
    .wr_addr (wb_rd_number),
    .wr_data (wb_result)
  );

  assign supported = in_valid && op_supported(fields.opcode);
  assign uses_rs2  = op_uses_rs2(fields.opcode);

  // A bubble in execute carries rd_number 0, so the stall lasts one cycle:
  // next cycle the producer's result arrives through the writeback bypass.
  assign hazard = supported && (rd_number_reg != '0) &&
                  ((fields.rs1 == rd_number_reg) ||
                   (uses_rs2 && (fields.rs2 == rd_number_reg)));

  assign in_ready = !hazard;
  assign issue    = supported && !hazard;

  always_comb begin
    pc_next        = '0;
    rs1_val_next   = '0;
    rs2_val_next   = '0;
    rd_number_next = '0;
    immediate_next = '0;
    func7_next     = '0;
    func3_next     = '0;
    opcode_next    = '0;
    illegal_next   = in_valid && !op_supported(fields.opcode);
    if (issue) begin
      pc_next        = in_pc;
      rs1_val_next   = rf_rs1_data;
      rs2_val_next   = uses_rs2 ? rf_rs2_data : '0;
      rd_number_next = fields.rd;
      immediate_next = uses_rs2 ? '0 : sext_imm_i(instr);
      func7_next     = fields.func7;
      func3_next     = fields.func3;
      opcode_next    = fields.opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg        <= '0;
      rs1_val_reg   <= '0;
      rs2_val_reg   <= '0;
      rd_number_reg <= '0;
      immediate_reg <= '0;
      func7_reg     <= '0;
      func3_reg     <= '0;
      opcode_reg    <= '0;
      illegal_reg   <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      rs1_val_reg   <= rs1_val_next;
      rs2_val_reg   <= rs2_val_next;
      rd_number_reg <= rd_number_next;
      immediate_reg <= immediate_next;
      func7_reg     <= func7_next;
      func3_reg     <= func3_next;
      opcode_reg    <= opcode_next;
      illegal_reg   <= illegal_next;
    end
  end

  assign pc            = pc_reg;
  assign rs1_val       = rs1_val_reg;
  assign rs2_val       = rs2_val_reg;
  assign rd_number     = rd_number_reg;
  assign immediate     = immediate_reg;
  assign func7         = func7_reg;
  assign func3         = func3_reg;
  assign opcode        = opcode_reg;
  assign illegal_instr = illegal_reg;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a reference model predicts every output
// cycle, a monitor compares the DUT against the queued predictions.
module tb_id_stage;

  localparam logic [6:0] T_OP_R = 7'b0110011;
  localparam logic [6:0] T_OP_I = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  wb_rd_number = '0;
  logic [31:0] wb_result = '0;
  logic [31:0] pc, rs1_val, rs2_val, immediate;
  logic [4:0]  rd_number;
  logic [6:0]  func7, opcode;
  logic [2:0]  func3;
  logic        illegal_instr;

  id_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .in_pc(in_pc), .wb_rd_number(wb_rd_number),
    .wb_result(wb_result), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd_number(rd_number), .immediate(immediate), .func7(func7),
    .func3(func3), .opcode(opcode), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic        ill;
  } out_t;

  typedef struct packed {
    out_t o;
    logic rdy;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model state: architectural registers, what decode currently
  // shows, and what execute will write back.
  logic [31:0] m_rf [32];
  out_t        m_out = '0;
  out_t        m_next = '0;
  logic        m_ready = 1'b1;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_res = '0;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (a == wb_rd_number) return wb_result;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] exec_result(input out_t o);
    if (o.op == T_OP_I) return o.rs1 + o.imm;
    return o.rs1 + o.rs2;
  endfunction

  task automatic cycle(input logic rst, input logic v, input logic [31:0] ins,
                       input logic [31:0] p, input logic fwb,
                       input logic [4:0] frd, input logic [31:0] fres);
    logic [6:0] op;
    logic       sup, use2, haz;
    logic [4:0] s1, s2;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_out  = '0;
      ex_rd  = '0;
      ex_res = '0;
    end else begin
      if (wb_rd_number != 5'd0) m_rf[wb_rd_number] = wb_result;
      ex_rd  = m_out.rd;
      ex_res = exec_result(m_out);
      m_out  = m_next;
    end
    #1;
    reset        = rst;
    in_valid     = v;
    instr        = ins;
    in_pc        = p;
    wb_rd_number = fwb ? frd : ex_rd;
    wb_result    = fwb ? fres : ex_res;
    op   = ins[6:0];
    s1   = ins[19:15];
    s2   = ins[24:20];
    sup  = v && (op == T_OP_R || op == T_OP_I);
    use2 = (op == T_OP_R);
    haz  = sup && m_out.rd != 5'd0 && (s1 == m_out.rd || (use2 && s2 == m_out.rd));
    m_ready = !haz;
    m_next  = '0;
    m_next.ill = v && !sup;
    if (sup && !haz) begin
      m_next.pc  = p;
      m_next.rs1 = model_read(s1);
      m_next.rs2 = use2 ? model_read(s2) : 32'd0;
      m_next.rd  = ins[11:7];
      m_next.imm = use2 ? 32'd0 : {{20{ins[31]}}, ins[31:20]};
      m_next.f7  = ins[31:25];
      m_next.f3  = ins[14:12];
      m_next.op  = op;
    end
    sb_q.push_back('{o: m_out, rdy: m_ready});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] p);
    cycle(1'b0, 1'b1, ins, p, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    int k = $urandom_range(0, 19);
    if (k < 9)       op = T_OP_R;
    else if (k < 18) op = T_OP_I;
    else begin
      op = 7'($urandom);
      if (op == T_OP_R || op == T_OP_I) op = 7'b0000011;
    end
    return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'($urandom_range(0, 7)), op};
  endfunction

  // Monitor: every cycle the DUT presents one output set plus in_ready.
  initial begin
    exp_t e;
    out_t got;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = '{pc: pc, rs1: rs1_val, rs2: rs2_val, rd: rd_number, imm: immediate,
                f7: func7, f3: func3, op: opcode, ill: illegal_instr};
        n_vec++;
        if (got !== e.o || in_ready !== e.rdy) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: got out=%h ready=%b, expected out=%h ready=%b",
                   $time, got, in_ready, e.o, e.rdy);
        end
      end
    end
  end

  initial begin
    logic        have;
    logic [31:0] ri, rp;

    // Reset held two cycles with a valid instruction present
    cycle(1'b1, 1'b1, 32'h00500093, 32'h10, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 1'b1, 32'h00500093, 32'h10, 1'b0, 5'd0, 32'd0);
    idle();
    @(negedge clk);
    chk("reset_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_rd", {27'd0, rd_number}, 32'd0);
    chk("reset_opcode", {25'd0, opcode}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_instr}, 32'd0);
    chk("reset_pc", pc, 32'd0);
    for (int i = 1; i < 32; i++) begin
      issue({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, T_OP_R}, 32'h20 + 32'(i));
    end
    idle();
    @(negedge clk);
    chk("x31_cleared", rs1_val, 32'd0);

    // addi x1,x0,5
    issue(32'h00500093, 32'h100);
    idle();
    @(negedge clk);
    chk("addi_opcode", {25'd0, opcode}, 32'h13);
    chk("addi_rd", {27'd0, rd_number}, 32'd1);
    chk("addi_func3", {29'd0, func3}, 32'd0);
    chk("addi_imm", immediate, 32'd5);
    chk("addi_rs1", rs1_val, 32'd0);
    chk("addi_rs2", rs2_val, 32'd0);
    chk("addi_pc", pc, 32'h100);

    // addi x1,x0,-1 then add x4,x3,x3 with a same-cycle writeback of x3
    issue(32'hFFF00093, 32'h104);
    cycle(1'b0, 1'b1, 32'h00318233, 32'h108, 1'b1, 5'd3, 32'hDEADBEEF);
    @(negedge clk);
    chk("sext_imm", immediate, 32'hFFFFFFFF);
    idle();
    @(negedge clk);
    chk("bypass_rs1", rs1_val, 32'hDEADBEEF);
    chk("bypass_rs2", rs2_val, 32'hDEADBEEF);

    // Dependent pair: addi x1,x0,5 then add x2,x1,x1
    issue(32'h00500093, 32'h200);
    issue(32'h00108133, 32'h204);
    @(negedge clk);
    chk("stall_ready", {31'd0, in_ready}, 32'd0);
    issue(32'h00108133, 32'h204);
    @(negedge clk);
    chk("stall_release", {31'd0, in_ready}, 32'd1);
    chk("bubble_rd", {27'd0, rd_number}, 32'd0);
    chk("bubble_opcode", {25'd0, opcode}, 32'd0);
    idle();
    @(negedge clk);
    chk("dep_rs1", rs1_val, 32'd5);
    chk("dep_rs2", rs2_val, 32'd5);
    chk("dep_rd", {27'd0, rd_number}, 32'd2);

    // x0 stays zero; rs=0 against a bubble does not stall
    idle();
    cycle(1'b0, 1'b1, 32'h000002B3, 32'h300, 1'b1, 5'd0, 32'h1234);
    @(negedge clk);
    chk("x0_no_stall", {31'd0, in_ready}, 32'd1);
    idle();
    @(negedge clk);
    chk("x0_rs1", rs1_val, 32'd0);
    chk("x0_rs2", rs2_val, 32'd0);
    chk("x0_rd", {27'd0, rd_number}, 32'd5);

    // Unsupported opcode (load)
    issue(32'h00000003, 32'h400);
    @(negedge clk);
    chk("illegal_ready", {31'd0, in_ready}, 32'd1);
    idle();
    @(negedge clk);
    chk("illegal_pulse", {31'd0, illegal_instr}, 32'd1);
    chk("illegal_bubble", {27'd0, rd_number}, 32'd0);
    idle();
    @(negedge clk);
    chk("illegal_clear", {31'd0, illegal_instr}, 32'd0);

    // Reset arriving while stalled cancels the stall
    issue(32'h00500093, 32'h500);
    issue(32'h00108133, 32'h504);
    cycle(1'b1, 1'b1, 32'h00108133, 32'h504, 1'b0, 5'd0, 32'd0);
    issue(32'h00108133, 32'h504);
    @(negedge clk);
    chk("reset_cancels_stall", {31'd0, in_ready}, 32'd1);

    // Randomized traffic, fetch holding the instruction while stalled
    have = 1'b0;
    ri = '0;
    rp = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        ri = rand_instr();
        rp = rp + 32'd4;
        have = 1'b1;
      end
      cycle(1'($urandom_range(0, 99) == 0), have, ri, rp, 1'b0, 5'd0, 32'd0);
      if (have && m_ready) have = 1'b0;
    end
    idle();

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the pipeline. Accepts a fetched instruction and its PC, reads the integer register file, and drives the registered decoded fields consumed by the execute stage.
- Owns the 32x32 register file. The register file is written from the execute stage's registered rd_number_out/result_out, which act as writeback.
- Detects the one read-after-write hazard the pipeline has: a source register matching the instruction currently in execute. On that hazard it stalls fetch for one cycle and inserts a bubble.

Parameters:
- DATA_W, 32, datapath width (fixed at 32; parameter exists for readability only).
- CLEAR_RF_ON_RESET, 1, when 1 the register file is zeroed on reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  instr/in_pc valid from fetch
- in_ready  output  1  instruction accepted this cycle
- instr  input  32  raw RV32I instruction
- in_pc  input  32  instruction PC
- wb_rd_number  input  5  writeback destination (execute rd_number_out)
- wb_result  input  32  writeback data (execute result_out)
- pc  output  32  registered PC to execute
- rs1_val  output  32  registered rs1 operand
- rs2_val  output  32  registered rs2 operand
- rd_number  output  5  registered destination; 0 means bubble
- immediate  output  32  sign-extended I-immediate; 0 for R-type
- func7  output  7  instr[31:25]
- func3  output  3  instr[14:12]
- opcode  output  7  instr[6:0]; 0 for bubble
- illegal_instr  output  1  one-cycle pulse; unsupported opcode was dropped

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: all registered outputs 0 and illegal_instr 0. in_ready is combinational and reads 1 after reset. If CLEAR_RF_ON_RESET=1, x1..x31 are set to 0. Reset mid-stall cancels the stall.
- Latency: one cycle. An instruction accepted in cycle t is on the outputs in cycle t+1.
- Register file writes: on posedge when wb_rd_number != 0. x0 always reads 0.
- Register file reads: combinational, with write-through bypass. If a source register equals wb_rd_number (and is nonzero), the read returns wb_result in that same cycle.
- Supported opcodes:
  - 0110011 (R-type): uses rs1 and rs2; immediate = 0.
  - 0010011 (I-type): uses rs1 only; rs2_val = 0; immediate = {{20{instr[31]}}, instr[31:20]}.
- Unsupported opcode with in_valid=1: the instruction is accepted (in_ready=1), a bubble is issued, and illegal_instr=1 for that output cycle.
- Hazard condition: in_valid && supported && rd_number (current output) != 0 && a used source register == rd_number.
  - While the hazard holds: in_ready=0 and a bubble is loaded. The instruction is held by fetch and issued the next cycle, reading the producer's result through the bypass.
- Bubble: pc, rd_number, opcode, func3, func7, immediate, rs1_val and rs2_val all 0.
- in_valid=0: bubble loaded, in_ready=1.
- Handshake: fetch must hold instr/in_pc stable while in_valid=1 and in_ready=0.
- Stall length: at most one cycle per instruction.
- States:
  - ISSUE: normal operation.
  - STALL: implicit, because the bubble's rd_number=0. No explicit FSM register is required.

Decomposition:
- Shared package (riscv_pkg):
  - opcode constants OP_ALU=0110011 and OP_ALUI=0010011;
  - field bit positions;
  - a function for I-immediate sign extension.
  - The execute stage migrates to the same constants.
- One sub-module, reg_file:
  - 32x32 storage;
  - 2 combinational read ports;
  - 1 write port;
  - write-through bypass;
  - synchronous reset clear.
- Hazard and decode logic stay in id_stage.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> all outputs 0, illegal_instr 0, in_ready 1; afterwards reading x1..x31 returns 0.
- Accept addi x1,x0,5 (0x00500093) -> next cycle opcode=0010011, rd_number=1, func3=0, immediate=5, rs1_val=0, rs2_val=0, pc=in_pc.
- Sign extension: addi x1,x0,-1 (0xFFF00093) -> immediate=0xFFFFFFFF; then add x4,x3,x3 (0x00318233) presented with wb_rd_number=3, wb_result=0xDEADBEEF in the same cycle -> rs1_val=rs2_val=0xDEADBEEF.
- Dependent pair: addi x1,x0,5 then add x2,x1,x1 (0x00108133); drive wb from a model of execute:
  - in_ready=0 for exactly one cycle;
  - one bubble (rd_number=0, opcode=0) is issued;
  - add then issues with rs1_val=rs2_val=5, rd_number=2.
- x0 protection: wb_rd_number=0, wb_result=0x1234, then add x5,x0,x0 -> rs1_val=rs2_val=0; no stall when an output rd_number=0 matches rs=0.
- Illegal: instr=0x00000003 (load) -> in_ready=1, next cycle bubble with illegal_instr=1 for one cycle, then 0.
